// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-FIFO-to-consumer signal bundle; master drives strobe/ready/clear, slave is the FIFO.
// UART_RX_FIFO_LEVEL_EN adds the o_Level / o_Almost_Full outputs.
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8
`ifdef UART_RX_FIFO_LEVEL_EN
    ,
    parameter int DEPTH      = 16
`endif
);
    logic                  i_RX_Data_Valid;
    logic [DATA_WIDTH-1:0] i_RX_Byte;
    logic                  o_Data_Valid;
    logic                  i_Data_Ready;
    logic [DATA_WIDTH-1:0] o_Data;
    logic                  o_Empty;
    logic                  o_Full;
    logic                  o_Overflow;
    logic                  i_Clear_Overflow;
`ifdef UART_RX_FIFO_LEVEL_EN
    logic [$clog2(DEPTH):0] o_Level;
    logic                   o_Almost_Full;

    modport master (
        output i_RX_Data_Valid, i_RX_Byte, i_Data_Ready, i_Clear_Overflow,
        input  o_Data_Valid, o_Data, o_Empty, o_Full, o_Overflow, o_Level, o_Almost_Full
    );
    modport slave (
        input  i_RX_Data_Valid, i_RX_Byte, i_Data_Ready, i_Clear_Overflow,
        output o_Data_Valid, o_Data, o_Empty, o_Full, o_Overflow, o_Level, o_Almost_Full
    );
`else
    modport master (
        output i_RX_Data_Valid, i_RX_Byte, i_Data_Ready, i_Clear_Overflow,
        input  o_Data_Valid, o_Data, o_Empty, o_Full, o_Overflow
    );
    modport slave (
        input  i_RX_Data_Valid, i_RX_Byte, i_Data_Ready, i_Clear_Overflow,
        output o_Data_Valid, o_Data, o_Empty, o_Full, o_Overflow
    );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// FWFT receive buffer: strobed byte is valid 1 cycle later; bytes arriving while full are dropped
// and set sticky o_Overflow. UART_RX_FIFO_LEVEL_EN adds o_Level and o_Almost_Full.
module uart_rx_fifo #(
    parameter int DEPTH        = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int AFULL_THRESH = 12
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("uart_rx_fifo: AFULL_THRESH must be within 1..DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  overflow;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic drop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign pop   = !empty && bus.i_Data_Ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign push  = bus.i_RX_Data_Valid && (!full || pop);
    assign drop  = bus.i_RX_Data_Valid && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            if (drop) begin
                overflow <= 1'b1;
            end else if (bus.i_Clear_Overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage is not reset; an in-flight strobe during reset is not written.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= bus.i_RX_Byte;
        end
    end

    assign bus.o_Data_Valid = !empty;
    assign bus.o_Empty      = empty;
    assign bus.o_Full       = full;
    assign bus.o_Overflow   = overflow;
    assign bus.o_Data       = empty ? '0 : mem[rd_ptr];

`ifdef UART_RX_FIFO_LEVEL_EN
    assign bus.o_Level       = count;
    assign bus.o_Almost_Full = (count >= CW'(AFULL_THRESH));
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

`ifdef UART_RX_FIFO_LEVEL_EN
    uart_rx_fifo_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();
`else
    uart_rx_fifo_if #(.DATA_WIDTH(8)) bus ();
`endif

    uart_rx_fifo #(.DEPTH(16), .DATA_WIDTH(8), .AFULL_THRESH(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mq [$];
    bit         movf;
    logic [7:0] got [$];
    logic [7:0] sent [$];
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [7:0] exp_data;
        exp_data = (mq.size() > 0) ? mq[0] : 8'h00;
        chk("empty",    32'(bus.o_Empty),      32'(mq.size() == 0));
        chk("full",     32'(bus.o_Full),       32'(mq.size() == 16));
        chk("valid",    32'(bus.o_Data_Valid), 32'(mq.size() != 0));
        chk("data",     32'(bus.o_Data),       32'(exp_data));
        chk("overflow", 32'(bus.o_Overflow),   32'(movf));
`ifdef UART_RX_FIFO_LEVEL_EN
        chk("level",    32'(bus.o_Level),       32'(mq.size()));
        chk("afull",    32'(bus.o_Almost_Full), 32'(mq.size() >= 12));
`endif
    endtask

    // Reference behaviour at one clock edge, expressed on a queue of bytes.
    task automatic model_edge(input bit v, input logic [7:0] b, input bit rdy, input bit clr);
        int n;
        bit p;
        bit d;
        n = mq.size();
        p = (n > 0) && rdy;
        d = v && (n == 16) && !p;
        if (p) void'(mq.pop_front());
        if (v && !d) mq.push_back(b);
        if (d) movf = 1'b1;
        else if (clr) movf = 1'b0;
    endtask

    task automatic step(input bit v, input logic [7:0] b, input bit rdy, input bit clr);
        bus.i_RX_Data_Valid  = v;
        bus.i_RX_Byte        = b;
        bus.i_Data_Ready     = rdy;
        bus.i_Clear_Overflow = clr;
        if (rdy && bus.o_Data_Valid) got.push_back(bus.o_Data);
        @(posedge clk);
        model_edge(v, b, rdy, clr);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_RX_Data_Valid  = 1'b1;
        bus.i_RX_Byte        = 8'($urandom);
        bus.i_Data_Ready     = 1'b0;
        bus.i_Clear_Overflow = 1'b0;
        @(posedge clk);
        mq.delete();
        movf = 1'b0;
        #1;
        rst = 1'b0;
        bus.i_RX_Data_Valid = 1'b0;
        check_all();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int cyc;
        logic [7:0] b;

        rst = 1'b1;
        bus.i_RX_Data_Valid  = 1'b0;
        bus.i_RX_Byte        = 8'h00;
        bus.i_Data_Ready     = 1'b0;
        bus.i_Clear_Overflow = 1'b0;
        do_reset();
        chk("rst_empty", 32'(bus.o_Empty), 32'd1);
        chk("rst_data",  32'(bus.o_Data),  32'd0);

        // Reset mid-fill
        repeat (5) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        do_reset();
        chk("t1_empty", 32'(bus.o_Empty),    32'd1);
        chk("t1_data",  32'(bus.o_Data),     32'd0);
        chk("t1_ovf",   32'(bus.o_Overflow), 32'd0);
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("t1_a5", 32'(bus.o_Data), 32'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1_sole", 32'(bus.o_Empty), 32'd1);

        // Single byte held until ready
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("t2_valid", 32'(bus.o_Data_Valid), 32'd1);
        chk("t2_data",  32'(bus.o_Data),       32'h3C);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t2_hold", 32'(bus.o_Data), 32'h3C);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t2_empty", 32'(bus.o_Empty), 32'd1);

        // Fill, overflow, ordered drain
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("t3_full", 32'(bus.o_Full), 32'd1);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("t3_ovf", 32'(bus.o_Overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("t3_order", 32'(bus.o_Data), 32'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("t3_drained", 32'(bus.o_Empty), 32'd1);
        chk("t3_ovf_sticky", 32'(bus.o_Overflow), 32'd1);
        do_reset();
        chk("t3_rst_ovf", 32'(bus.o_Overflow), 32'd0);

        // Full with simultaneous pop and strobe
        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        chk("t4_full", 32'(bus.o_Full),     32'd1);
        chk("t4_ovf",  32'(bus.o_Overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("t4_last", 32'(bus.o_Data), 32'h77);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Clear versus drop in the same cycle
        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b1);
        chk("t5_set_wins", 32'(bus.o_Overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t5_clear", 32'(bus.o_Overflow), 32'd0);
        repeat (16) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Streaming across pointer wrap with ready toggling
        got.delete();
        sent.delete();
        k = 0;
        cyc = 0;
        while (k < 40 && cyc < 400) begin
            if (mq.size() < 15) begin
                b = 8'($urandom);
                step(1'b1, b, (cyc % 2) == 0, 1'b0);
                sent.push_back(b);
                k++;
            end else begin
                step(1'b0, 8'h00, (cyc % 2) == 0, 1'b0);
            end
            cyc++;
        end
        repeat (20) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t6_count", 32'(got.size()), 32'd40);
        for (int i = 0; i < 40; i++) begin
            if (i < got.size()) chk("t6_seq", 32'(got[i]), 32'(sent[i]));
        end

        // Random traffic including drops, clears and occasional reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(63) == 0) do_reset();
            else step($urandom_range(3) != 0, 8'($urandom), $urandom_range(2) == 0,
                      $urandom_range(15) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
